// File: rtl/mux_nx1_rr.sv
// N-to-1 registered multiplexer with per-channel valid/ready handshake.
// Picks one channel per cycle by explicit select or round-robin and holds it in a one-entry output register.
module mux_nx1_rr #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N*W-1:0] i_data,
    input  logic [N-1:0]   i_valid,
    output logic [N-1:0]   i_ready,
    output logic [W-1:0]   y,
    output logic           y_valid,
    input  logic           y_ready,
    output logic [SW-1:0]  y_src
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] gnt_idx_p0;
    logic          gnt_p0;
    logic          load;
    logic          xfer;
    logic [W-1:0]  data_p0;

    // Grant decision: fixed select or round-robin scan starting after rr_ptr
    always_comb begin
        int c;
        gnt_p0     = 1'b0;
        gnt_idx_p0 = '0;
        c          = 0;
        if (!mode) begin
            if ((int'(sel) < N) && i_valid[sel]) begin
                gnt_p0     = 1'b1;
                gnt_idx_p0 = sel;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = int'(rr_ptr) + k;
                if (c >= N) c = c - N;
                if (!gnt_p0 && i_valid[SW'(c)]) begin
                    gnt_p0     = 1'b1;
                    gnt_idx_p0 = SW'(c);
                end
            end
        end
    end

    assign y_valid = (state == FULL);
    assign load    = ~y_valid | y_ready;
    // Gating with rst_n keeps every i_ready low while reset is held
    assign xfer    = gnt_p0 & load & rst_n;

    always_comb begin
        data_p0 = '0;
        i_ready = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt_idx_p0 == SW'(k)) begin
                data_p0    = i_data[k*W +: W];
                i_ready[k] = xfer;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (xfer) state_nxt = FULL;
            FULL:    if (y_ready && !xfer) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            y      <= '0;
            y_src  <= '0;
            rr_ptr <= SW'(N-1);
        end else begin
            state <= state_nxt;
            if (xfer) begin
                y     <= data_p0;
                y_src <= gnt_idx_p0;
                if (mode) rr_ptr <= gnt_idx_p0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Scoreboard bench for mux_nx1_rr: a reference grant model pushes expected words,
// which are compared against the output register while it holds data.
module tb_mux_nx1_rr;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [SW-1:0] s;
    } ent_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N*W-1:0] i_data;
    logic [N-1:0]   i_valid;
    logic [N-1:0]   i_ready;
    logic [W-1:0]   y;
    logic           y_valid;
    logic           y_ready;
    logic [SW-1:0]  y_src;

    ent_t q[$];
    int   m_ptr;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mux_nx1_rr #(.N(N), .W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode),
        .sel     (sel),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_src   (y_src)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic m, input int s, input logic [N-1:0] v, input int p);
        int c;
        if (!m) return (s < N && v[s]) ? s : -1;
        c = p;
        repeat (N) begin
            c = (c == N-1) ? 0 : c + 1;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic rand_data();
        for (int k = 0; k < N; k++) i_data[k*W +: W] = W'($urandom);
    endtask

    // One clock: check outputs at the falling edge, update the model, advance past the rising edge
    task automatic step(input string tag);
        int           g;
        logic         ld;
        logic [N-1:0] exp_rdy;
        ent_t         e;
        @(negedge clk);
        chk({tag, ".y_valid"}, 32'(y_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, ".y"}, 32'(y), 32'(q[0].d));
            chk({tag, ".y_src"}, 32'(y_src), 32'(q[0].s));
        end
        ld      = (q.size() == 0) || y_ready;
        g       = model_grant(mode, int'(sel), i_valid, m_ptr);
        exp_rdy = (ld && g >= 0) ? N'(1 << g) : '0;
        chk({tag, ".i_ready"}, 32'(i_ready), 32'(exp_rdy));
        if (q.size() != 0 && y_ready) void'(q.pop_front());
        if (ld && g >= 0) begin
            e.d = i_data[g*W +: W];
            e.s = SW'(g);
            q.push_back(e);
            if (mode) m_ptr = g;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".y"}, 32'(y), 32'h0);
        chk({tag, ".y_valid"}, 32'(y_valid), 32'h0);
        chk({tag, ".y_src"}, 32'(y_src), 32'h0);
        chk({tag, ".i_ready"}, 32'(i_ready), 32'h0);
    endtask

    initial begin
        // Reset asserted with every channel valid
        rst_n   = 1'b0;
        mode    = 1'b1;
        sel     = '0;
        i_valid = 4'hF;
        y_ready = 1'b1;
        rand_data();
        #1;
        chk_reset_state("rst_assert");
        repeat (2) begin
            @(negedge clk);
            chk_reset_state("rst_hold");
        end
        i_valid = '0;
        #2 rst_n = 1'b1;
        #1;
        chk_reset_state("rst_release");
        m_ptr = N-1;
        q.delete();
        @(posedge clk);
        #1;

        // Round-robin fairness: all valid, consumer always ready
        mode    = 1'b1;
        i_valid = 4'hF;
        y_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            step("rr_fair");
        end

        // Fixed select: ch2 granted, others ignored
        mode    = 1'b0;
        sel     = 2'd2;
        i_valid = 4'b0101;
        rand_data();
        i_data[2*W +: W] = 8'hA5;
        step("fixed_sel2");
        sel = 2'd1;
        rand_data();
        step("fixed_sel1");
        step("fixed_drain");
        step("fixed_empty");

        // Round-robin skip and wrap
        mode    = 1'b1;
        i_valid = 4'b0010;
        rand_data();
        step("rr_ptr1");
        i_valid = 4'b0001;
        rand_data();
        step("rr_wrap");
        i_valid = 4'b1001;
        rand_data();
        step("rr_skip3");
        rand_data();
        step("rr_skip0");
        step("rr_tail");

        // Backpressure: output held while consumer stalls
        i_valid = 4'hF;
        y_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            step("bp_hold");
        end
        y_ready = 1'b1;
        rand_data();
        step("bp_release");
        rand_data();
        step("bp_after");

        // Reset mid-stream during continuous round-robin traffic
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step("rr_stream");
        end
        #2 rst_n = 1'b0;
        #1;
        chk_reset_state("rst_mid");
        q.delete();
        m_ptr = N-1;
        @(posedge clk);
        #1;
        chk_reset_state("rst_mid_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            step("rr_restart");
        end
        i_valid = '0;
        step("final_drain");
        step("final_empty");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
